brom_scan_ctrl: RTL

- Sequences a single-port block ROM (synchronous read, fixed read latency) across a programmable address window.
- Reports the maximum data word, the address of its first occurrence, and the word count.
- Replaces free-running address counters with a start/busy/done controller that the top level, or a later arbiter, can trigger on demand.
- Sits between the control logic and the ROM instance; it is the ROM's only address master.

---
 rtl/brom_pkg.sv | 24 ++
 rtl/brom_max_tracker.sv | 99 +++++++++
 rtl/brom_scan_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/brom_pkg.sv
// -----------------------------------------------------------------------------
// brom_pkg
// Shared types and constants for the block-ROM scan controller.
//   - brom_state_e : controller states (IDLE, ISSUE, DRAIN, DONE)
//   - BROM_ADDR_W / BROM_DATA_W : default ROM address / data widths
//   - BROM_RD_LAT_MIN / BROM_RD_LAT_MAX : legal ROM read latency range
// -----------------------------------------------------------------------------
package brom_pkg;

  localparam int unsigned BROM_ADDR_W     = 4;
  localparam int unsigned BROM_DATA_W     = 4;

  // ROM read latency may only be 1 or 2 cycles.
  localparam int unsigned BROM_RD_LAT_MIN = 1;
  localparam int unsigned BROM_RD_LAT_MAX = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } brom_state_e;

endpackage

// File: rtl/brom_max_tracker.sv
// -----------------------------------------------------------------------------
// brom_max_tracker
// Consumes valid-tagged ROM samples and keeps the running maximum, the address
// of its first occurrence and the number of samples seen.
// Optional feature macro: BROM_SCAN_SUM_EN adds a non-overflowing sum output.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   clr             : start of a new scan (clears results)
//   clr_addr        : base address loaded into max_addr on clear
//   smp_vld         : a ROM sample is present this cycle
//   smp_addr        : address the sample was read from
//   smp_data        : ROM data word
//   max_val         : running / final maximum
//   max_addr        : first address at which max_val was seen
//   count           : number of samples accumulated
//   sum             : (BROM_SCAN_SUM_EN only) sum of all samples
// -----------------------------------------------------------------------------
module brom_max_tracker
  import brom_pkg::*;
#(
  parameter int unsigned ADDR_W = BROM_ADDR_W,
  parameter int unsigned DATA_W = BROM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              smp_vld,
  input  logic [ADDR_W-1:0] smp_addr,
  input  logic [DATA_W-1:0] smp_data,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W:0]   count
`ifdef BROM_SCAN_SUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] sum
`endif
);

  logic [DATA_W-1:0] max_val_r;
  logic [ADDR_W-1:0] max_addr_r;
  logic [ADDR_W:0]   count_r;
  logic              take_s;

  // The first sample of a scan (count still zero) always loads; later samples
  // need a strictly larger value so ties keep the earliest-scanned address.
  assign take_s = (count_r == {(ADDR_W+1){1'b0}}) || (smp_data > max_val_r);

  // Maximum / address / count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_val_r  <= {DATA_W{1'b0}};
      max_addr_r <= {ADDR_W{1'b0}};
      count_r    <= {(ADDR_W+1){1'b0}};
    end else if (clr) begin
      max_val_r  <= {DATA_W{1'b0}};
      max_addr_r <= clr_addr;
      count_r    <= {(ADDR_W+1){1'b0}};
    end else if (smp_vld) begin
      count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
      if (take_s) begin
        max_val_r  <= smp_data;
        max_addr_r <= smp_addr;
      end else begin
        max_val_r  <= max_val_r;
        max_addr_r <= max_addr_r;
      end
    end else begin
      max_val_r  <= max_val_r;
      max_addr_r <= max_addr_r;
      count_r    <= count_r;
    end
  end

  assign max_val  = max_val_r;
  assign max_addr = max_addr_r;
  assign count    = count_r;

`ifdef BROM_SCAN_SUM_EN
  // Widened by ADDR_W bits so a full-ROM scan of all-ones words cannot wrap.
  logic [DATA_W+ADDR_W-1:0] sum_r;

  // Sample accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_r <= {(DATA_W+ADDR_W){1'b0}};
    end else if (clr) begin
      sum_r <= {(DATA_W+ADDR_W){1'b0}};
    end else if (smp_vld) begin
      sum_r <= sum_r + {{ADDR_W{1'b0}}, smp_data};
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;
`endif

endmodule

// File: rtl/brom_scan_ctrl.sv
// -----------------------------------------------------------------------------
// brom_scan_ctrl
// Start/busy/done controller that walks a synchronous block ROM across an
// inclusive, wrapping address window [base_addr .. last_addr] and reports the
// maximum word, its first address and the number of words read.
// Optional feature macro: BROM_SCAN_SUM_EN adds the 'sum' output.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   start                : scan request, honoured only when idle
//   base_addr, last_addr : window bounds, captured when start is accepted
//   busy                 : scan in progress (ISSUE, DRAIN, DONE)
//   done                 : one-cycle completion pulse
//   rom_addr, rom_en     : ROM read address / enable
//   rom_dout             : ROM data, RD_LAT cycles after its address
//   max_val, max_addr    : maximum word and first address holding it
//   count                : words scanned (ADDR_W+1 bits, holds a full ROM)
//   sum                  : (BROM_SCAN_SUM_EN only) sum of words scanned
// -----------------------------------------------------------------------------
module brom_scan_ctrl
  import brom_pkg::*;
#(
  parameter int unsigned ADDR_W = BROM_ADDR_W,
  parameter int unsigned DATA_W = BROM_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] last_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_en,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [DATA_W-1:0] max_val,
  output logic [ADDR_W-1:0] max_addr,
  output logic [ADDR_W:0]   count
`ifdef BROM_SCAN_SUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] sum
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [1:0]        DRAIN_LAST = 2'(RD_LAT - 1);

  brom_state_e       state_r;
  brom_state_e       state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] last_r;
  logic [1:0]        drain_cnt_r;
  logic              start_acc_s;
  logic              at_last_s;
  logic              issue_s;
  logic              busy_nxt_s;
  logic              done_nxt_s;
  logic              rom_en_nxt_s;
  logic              busy_r;
  logic              done_r;
  logic              rom_en_r;

  // Valid / address tags travelling alongside the ROM read latency.
  logic [RD_LAT-1:0] vld_pipe_r;
  logic [ADDR_W-1:0] tag_pipe_r [RD_LAT];

  assign start_acc_s = (state_r == IDLE) && start;
  assign at_last_s   = (addr_r == last_r);
  assign issue_s     = (state_r == ISSUE);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt_s = ISSUE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ISSUE: begin
        if (at_last_s) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ISSUE;
        end
      end
      DRAIN: begin
        if (drain_cnt_r == DRAIN_LAST) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = DRAIN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output decode from the upcoming state, so the outputs can be registered
  // and still line up with the state they describe.
  always_comb begin
    busy_nxt_s   = 1'b0;
    done_nxt_s   = 1'b0;
    rom_en_nxt_s = 1'b0;
    case (state_nxt_s)
      IDLE: begin
        busy_nxt_s   = 1'b0;
        done_nxt_s   = 1'b0;
        rom_en_nxt_s = 1'b0;
      end
      ISSUE: begin
        busy_nxt_s   = 1'b1;
        done_nxt_s   = 1'b0;
        rom_en_nxt_s = 1'b1;
      end
      DRAIN: begin
        busy_nxt_s   = 1'b1;
        done_nxt_s   = 1'b0;
        rom_en_nxt_s = 1'b0;
      end
      DONE: begin
        busy_nxt_s   = 1'b1;
        done_nxt_s   = 1'b1;
        rom_en_nxt_s = 1'b0;
      end
      default: begin
        busy_nxt_s   = 1'b0;
        done_nxt_s   = 1'b0;
        rom_en_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      rom_en_r <= 1'b0;
    end else begin
      busy_r   <= busy_nxt_s;
      done_r   <= done_nxt_s;
      rom_en_r <= rom_en_nxt_s;
    end
  end

  // Address generator, window capture and drain counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r      <= {ADDR_W{1'b0}};
      last_r      <= {ADDR_W{1'b0}};
      drain_cnt_r <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            addr_r <= base_addr;
            last_r <= last_addr;
          end else begin
            addr_r <= addr_r;
            last_r <= last_r;
          end
        end
        ISSUE: begin
          // Natural overflow gives the modulo-2^ADDR_W wrap through address 0.
          if (!at_last_s) begin
            addr_r <= addr_r + ADDR_ONE;
          end else begin
            addr_r <= addr_r;
          end
        end
        default: begin
          addr_r <= addr_r;
          last_r <= last_r;
        end
      endcase
      if (state_r == DRAIN) begin
        drain_cnt_r <= drain_cnt_r + 2'd1;
      end else begin
        drain_cnt_r <= 2'd0;
      end
    end
  end

  generate
    if (RD_LAT == BROM_RD_LAT_MIN) begin : g_lat1
      // Single-stage valid/address tag.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe_r    <= 1'b0;
          tag_pipe_r[0] <= {ADDR_W{1'b0}};
        end else begin
          vld_pipe_r    <= issue_s;
          tag_pipe_r[0] <= addr_r;
        end
      end
    end else begin : g_latn
      // Multi-stage valid/address tag shift register.
      always_ff @(posedge clk) begin
        if (rst) begin
          vld_pipe_r <= {RD_LAT{1'b0}};
          for (int i = 0; i < RD_LAT; i++) begin
            tag_pipe_r[i] <= {ADDR_W{1'b0}};
          end
        end else begin
          vld_pipe_r    <= {vld_pipe_r[RD_LAT-2:0], issue_s};
          tag_pipe_r[0] <= addr_r;
          for (int i = 1; i < RD_LAT; i++) begin
            tag_pipe_r[i] <= tag_pipe_r[i-1];
          end
        end
      end
    end
  endgenerate

  brom_max_tracker #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_tracker (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc_s),
    .clr_addr (base_addr),
    .smp_vld  (vld_pipe_r[RD_LAT-1]),
    .smp_addr (tag_pipe_r[RD_LAT-1]),
    .smp_data (rom_dout),
    .max_val  (max_val),
    .max_addr (max_addr),
    .count    (count)
`ifdef BROM_SCAN_SUM_EN
    ,
    .sum      (sum)
`endif
  );

  assign busy     = busy_r;
  assign done     = done_r;
  assign rom_en   = rom_en_r;
  assign rom_addr = addr_r;

endmodule
